// File: rtl/pe_sched_if.sv
// Start/config, buffer-read, PE-strobe and output-row signals of the
// convolution PE sequencing controller, bundled with host and controller views.
interface pe_sched_if #(
  parameter int ROW_W = 8,
  parameter int NC_W  = 9,
  parameter int K_W   = 4
);
  logic             start;
  logic [NC_W-1:0]  cfg_nc;
  logic [ROW_W-1:0] cfg_rows;
  logic [K_W-1:0]   cfg_ksize;
  logic             busy;
  logic             done;
  logic             fm_rd_en;
  logic [ROW_W-1:0] fm_rd_row;
  logic             kr_rd_en;
  logic [K_W-1:0]   kr_rd_row;
  logic [NC_W-1:0]  pe_nc;
  logic             pe_load;
  logic             pe_clear;
  logic             ofm_valid;
  logic [ROW_W-1:0] ofm_row;
  logic             ofm_ready;

  // Host / environment side: issues jobs and consumes rows.
  modport master (
    output start, cfg_nc, cfg_rows, cfg_ksize, ofm_ready,
    input  busy, done, fm_rd_en, fm_rd_row, kr_rd_en, kr_rd_row,
           pe_nc, pe_load, pe_clear, ofm_valid, ofm_row
  );

  // Controller side.
  modport slave (
    input  start, cfg_nc, cfg_rows, cfg_ksize, ofm_ready,
    output busy, done, fm_rd_en, fm_rd_row, kr_rd_en, kr_rd_row,
           pe_nc, pe_load, pe_clear, ofm_valid, ofm_row
  );
endinterface

// File: rtl/pe_sched_ctrl.sv
// Sequencing controller for the convolution PE: per output row it reads
// ksize fmap/kernel row pairs, loads them into the PE, waits out the PE
// latency, then hands the finished row downstream via valid/ready.
module pe_sched_ctrl #(
  parameter int ROW_W  = 8,
  parameter int NC_W   = 9,
  parameter int K_W    = 4,
  parameter int PE_LAT = 2
) (
  input logic       clk,
  input logic       rst,
  pe_sched_if.slave bus
);
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LD, S_WAIT, S_OUT, S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ROW_W-1:0] r;
  logic [ROW_W-1:0] rows_q;
  logic [K_W-1:0]   kr;
  logic [K_W-1:0]   ksize_q;
  logic [NC_W-1:0]  nc_q;
  logic [CNT_W-1:0] cnt;
  logic             degen;
  logic             kr_last;
  logic             r_last;
  logic             wait_last;

  // Any zero-sized dimension means there is no work: finish immediately.
  assign degen     = (bus.cfg_rows == '0) || (bus.cfg_ksize == '0) || (bus.cfg_nc == '0);
  assign kr_last   = (kr == ksize_q - K_W'(1));
  assign r_last    = (r == rows_q - ROW_W'(1));
  assign wait_last = (cnt == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = degen ? S_DONE : S_RD;
      S_RD:   state_nxt = S_LD;
      S_LD:   state_nxt = S_WAIT;
      S_WAIT: if (wait_last) state_nxt = kr_last ? S_OUT : S_RD;
      S_OUT:  if (bus.ofm_ready) state_nxt = r_last ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job config latch, row/kernel-row counters and PE latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r       <= '0;
      kr      <= '0;
      cnt     <= '0;
      rows_q  <= '0;
      ksize_q <= '0;
      nc_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rows_q  <= bus.cfg_rows;
            ksize_q <= bus.cfg_ksize;
            nc_q    <= bus.cfg_nc;
            r       <= '0;
            kr      <= '0;
          end
        end
        S_LD: cnt <= CNT_W'(PE_LAT);
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (wait_last && !kr_last) kr <= kr + K_W'(1);
        end
        S_OUT: begin
          if (bus.ofm_ready) begin
            kr <= '0;
            if (!r_last) r <= r + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state; addresses are zero outside their strobe.
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.fm_rd_en  = (state == S_RD);
    bus.kr_rd_en  = (state == S_RD);
    bus.fm_rd_row = (state == S_RD) ? (r + ROW_W'(kr)) : '0;
    bus.kr_rd_row = (state == S_RD) ? kr : '0;
    bus.pe_nc     = nc_q;
    bus.pe_load   = (state == S_LD);
    bus.pe_clear  = (state == S_LD) && (kr == '0);
    bus.ofm_valid = (state == S_OUT);
    bus.ofm_row   = (state == S_OUT) ? r : '0;
  end
endmodule

// File: tb/tb_pe_sched_ctrl.sv
// Scoreboard bench for pe_sched_ctrl: the driver pushes expected reads,
// loads, output rows and done cycles; monitors pop and compare on DUT events.
module tb_pe_sched_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_sched_if #(.ROW_W(8), .NC_W(9), .K_W(4)) bus_a ();
  pe_sched_if #(.ROW_W(8), .NC_W(9), .K_W(4)) bus_b ();

  pe_sched_ctrl #(.ROW_W(8), .NC_W(9), .K_W(4), .PE_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  pe_sched_ctrl #(.ROW_W(8), .NC_W(9), .K_W(4), .PE_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks = 0;
  int passes = 0;

  int exp_rd_a[$];
  int exp_ld_a[$];
  int exp_out_a[$];
  int exp_done_a[$];
  int exp_nc_a = 0;
  int exp_rd_b[$];
  int exp_out_b[$];
  int exp_done_b[$];

  bit bp_mode = 1'b0;
  int hold_a = 0;
  int prev_valid_a = 0;
  int prev_row_a = 0;
  int last_c = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected events for one job; degenerate jobs only produce a done pulse.
  task automatic push_a(input int rows, input int ks, input int nc, input int done_cyc);
    exp_nc_a = nc;
    if (rows != 0 && ks != 0 && nc != 0) begin
      for (int r = 0; r < rows; r++) begin
        for (int k = 0; k < ks; k++) begin
          exp_rd_a.push_back((((r + k) % 256) * 16) + k);
          exp_ld_a.push_back(k == 0 ? 1 : 0);
        end
        exp_out_a.push_back(r);
      end
    end
    exp_done_a.push_back(done_cyc);
  endtask

  task automatic start_a(input int rows, input int ks, input int nc, input int dlat);
    @(negedge clk);
    last_c = cyc;
    bus_a.cfg_rows  = rows[7:0];
    bus_a.cfg_ksize = ks[3:0];
    bus_a.cfg_nc    = nc[8:0];
    bus_a.start     = 1'b1;
    push_a(rows, ks, nc, cyc + dlat);
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic flush_a();
    exp_rd_a.delete();
    exp_ld_a.delete();
    exp_out_a.delete();
    exp_done_a.delete();
  endtask

  task automatic wait_a(input int budget);
    int n = 0;
    while (exp_done_a.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_done_a.size() != 0) begin
      chk("done_timeout_a", exp_done_a.size(), 0);
      flush_a();
    end
    chk("rd_left_a", exp_rd_a.size(), 0);
    chk("ld_left_a", exp_ld_a.size(), 0);
    chk("out_left_a", exp_out_a.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero_a(input string tag);
    chk({tag, "_busy"}, int'(bus_a.busy), 0);
    chk({tag, "_done"}, int'(bus_a.done), 0);
    chk({tag, "_fm_rd_en"}, int'(bus_a.fm_rd_en), 0);
    chk({tag, "_kr_rd_en"}, int'(bus_a.kr_rd_en), 0);
    chk({tag, "_pe_load"}, int'(bus_a.pe_load), 0);
    chk({tag, "_pe_clear"}, int'(bus_a.pe_clear), 0);
    chk({tag, "_ofm_valid"}, int'(bus_a.ofm_valid), 0);
    chk({tag, "_pe_nc"}, int'(bus_a.pe_nc), 0);
    chk({tag, "_fm_rd_row"}, int'(bus_a.fm_rd_row), 0);
    chk({tag, "_ofm_row"}, int'(bus_a.ofm_row), 0);
  endtask

  // Downstream for DUT A: always ready, or ready only after 5 stalled OUT cycles.
  always @(negedge clk) begin
    if (bus_a.ofm_valid) hold_a++;
    else hold_a = 0;
    bus_a.ofm_ready = !bp_mode || (hold_a >= 6);
  end

  // Monitor for DUT A.
  always @(posedge clk) begin
    int e;
    #1;
    if (rst) begin
      prev_valid_a = 0;
    end else begin
      if (int'(bus_a.fm_rd_en) + int'(bus_a.pe_load) + int'(bus_a.ofm_valid) > 1)
        chk("strobe_excl_a", 1, 0);
      if (bus_a.fm_rd_en) begin
        chk("kr_rd_en_a", int'(bus_a.kr_rd_en), 1);
        if (exp_rd_a.size() == 0) chk("rd_unexpected_a", 1, 0);
        else begin
          e = exp_rd_a.pop_front();
          chk("fm_rd_row_a", int'(bus_a.fm_rd_row), e / 16);
          chk("kr_rd_row_a", int'(bus_a.kr_rd_row), e % 16);
        end
      end
      if (bus_a.pe_load) begin
        if (exp_ld_a.size() == 0) chk("ld_unexpected_a", 1, 0);
        else begin
          e = exp_ld_a.pop_front();
          chk("pe_clear_a", int'(bus_a.pe_clear), e);
          chk("pe_nc_a", int'(bus_a.pe_nc), exp_nc_a);
        end
      end else if (bus_a.pe_clear) begin
        chk("clear_without_load_a", 1, 0);
      end
      if (prev_valid_a != 0) begin
        if (bus_a.ofm_ready) begin
          if (exp_out_a.size() == 0) chk("out_unexpected_a", 1, 0);
          else begin
            e = exp_out_a.pop_front();
            chk("ofm_row_a", prev_row_a, e);
          end
        end else begin
          chk("hold_valid_a", int'(bus_a.ofm_valid), 1);
          chk("hold_row_a", int'(bus_a.ofm_row), prev_row_a);
        end
      end
      prev_valid_a = int'(bus_a.ofm_valid);
      prev_row_a   = int'(bus_a.ofm_row);
      if (bus_a.done) begin
        chk("busy_at_done_a", int'(bus_a.busy), 1);
        if (exp_done_a.size() == 0) chk("done_unexpected_a", 1, 0);
        else begin
          e = exp_done_a.pop_front();
          chk("done_cycle_a", cyc, e);
        end
      end
    end
  end

  // Monitor for DUT B (ofm_ready tied high).
  always @(posedge clk) begin
    int e;
    #1;
    if (!rst) begin
      if (int'(bus_b.fm_rd_en) + int'(bus_b.pe_load) + int'(bus_b.ofm_valid) > 1)
        chk("strobe_excl_b", 1, 0);
      if (bus_b.fm_rd_en) begin
        if (exp_rd_b.size() == 0) chk("rd_unexpected_b", 1, 0);
        else begin
          e = exp_rd_b.pop_front();
          chk("fm_rd_row_b", int'(bus_b.fm_rd_row), e);
        end
      end
      if (bus_b.ofm_valid) begin
        if (exp_out_b.size() == 0) chk("out_unexpected_b", 1, 0);
        else begin
          e = exp_out_b.pop_front();
          chk("ofm_row_b", int'(bus_b.ofm_row), e);
        end
      end
      if (bus_b.done) begin
        if (exp_done_b.size() == 0) chk("done_unexpected_b", 1, 0);
        else begin
          e = exp_done_b.pop_front();
          chk("done_cycle_b", cyc, e);
        end
      end
    end
  end

  initial begin
    int n;
    bus_a.start = 1'b0;
    bus_a.cfg_nc = '0;
    bus_a.cfg_rows = '0;
    bus_a.cfg_ksize = '0;
    bus_b.start = 1'b0;
    bus_b.cfg_nc = '0;
    bus_b.cfg_rows = '0;
    bus_b.cfg_ksize = '0;
    bus_b.ofm_ready = 1'b1;

    // Reset state, before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk_outputs_zero_a("reset");
    chk("reset_busy_b", int'(bus_b.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Main job: 3 rows, 3 kernel rows, nc=4, downstream always ready.
    start_a(3, 3, 4, 40);
    wait_a(200);

    // Same job with 5 cycles of backpressure at every output row.
    bp_mode = 1'b1;
    start_a(3, 3, 4, 55);
    wait_a(200);
    bp_mode = 1'b0;

    // Degenerate configurations.
    start_a(0, 3, 4, 1);
    wait_a(20);
    start_a(3, 0, 4, 1);
    wait_a(20);
    start_a(3, 3, 0, 1);
    wait_a(20);

    // Reset during the WAIT of row 1 abandons the job.
    start_a(3, 3, 4, 40);
    repeat (15) @(negedge clk);
    chk("busy_before_reset", int'(bus_a.busy), 1);
    chk("pe_nc_before_reset", int'(bus_a.pe_nc), 4);
    #1 rst = 1'b1;
    #1;
    chk_outputs_zero_a("async_reset");
    flush_a();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_a(1, 2, 6, 10);
    wait_a(100);

    // start and config changes while busy are ignored.
    start_a(2, 1, 5, 11);
    repeat (2) @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.cfg_rows = 8'd7;
    bus_a.cfg_ksize = 4'd3;
    bus_a.cfg_nc = 9'd9;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_a(100);

    // PE_LAT=1 instance: 2 rows of 1 kernel row, 4 cycles per row.
    @(negedge clk);
    bus_b.cfg_rows = 8'd2;
    bus_b.cfg_ksize = 4'd1;
    bus_b.cfg_nc = 9'd3;
    bus_b.start = 1'b1;
    exp_rd_b.push_back(0);
    exp_rd_b.push_back(1);
    exp_out_b.push_back(0);
    exp_out_b.push_back(1);
    exp_done_b.push_back(cyc + 9);
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    while (exp_done_b.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_left_b", exp_done_b.size(), 0);
    chk("rd_left_b", exp_rd_b.size(), 0);
    chk("out_left_b", exp_out_b.size(), 0);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
